goal_referee: RTL and testbench

Parametrised match referee that replaces the fixed-geometry goal detector. Detects goals from the ball position with a multi-frame confirmation window, keeps saturating per-player scores, and runs a match clock with sudden-death overtime. Sequences a post-goal freeze and ball re-spawn, and declares the winner. Sits between the ball physics block (ball position in; freeze/ball_reset out) and the score/HUD renderer. Advances once per `frame_clk` edge (one edge per video frame).

---
 rtl/goal_referee_if.sv | 35 +++
 rtl/goal_referee.sv | 213 +++++++++++++++++++++
 tb/tb_goal_referee.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/goal_referee_if.sv
// Ball-physics / referee / HUD signal bundle. The physics side drives the ball and
// the match commands; the referee drives the scoring, freeze and match-state outputs.
interface goal_referee_if #(
  parameter int COORD_W = 10,
  parameter int SCORE_W = 4,
  parameter int TIMER_W = 13
);
  logic [COORD_W-1:0] ball_x;
  logic [COORD_W-1:0] ball_y;
  logic [COORD_W-1:0] ball_r;
  logic               game_restart;
  logic               pause;
  logic               goal_scored;
  logic               left_goal;
  logic [SCORE_W-1:0] p1_score;
  logic [SCORE_W-1:0] p2_score;
  logic               freeze;
  logic               ball_reset;
  logic [TIMER_W-1:0] time_left;
  logic               overtime;
  logic               game_over;
  logic               p1_wins;

  modport master (
    output ball_x, ball_y, ball_r, game_restart, pause,
    input  goal_scored, left_goal, p1_score, p2_score, freeze, ball_reset,
           time_left, overtime, game_over, p1_wins
  );

  modport slave (
    input  ball_x, ball_y, ball_r, game_restart, pause,
    output goal_scored, left_goal, p1_score, p2_score, freeze, ball_reset,
           time_left, overtime, game_over, p1_wins
  );
endinterface

// File: rtl/goal_referee.sv
// Match referee: multi-frame goal confirmation, saturating scores, match clock with
// sudden-death overtime, post-goal freeze / ball re-spawn and winner declaration.
module goal_referee #(
  parameter int COORD_W        = 10,
  parameter int SCORE_W        = 4,
  parameter int SCORE_MAX      = 9,
  parameter int WIN_SCORE      = 5,
  parameter int WIN_MARGIN     = 1,
  parameter int LEFT_GOAL_X    = 32,
  parameter int RIGHT_GOAL_X   = 604,
  parameter int GOAL_Y_TOP     = 176,
  parameter int GOAL_Y_BOTTOM  = 316,
  parameter int CONFIRM_FRAMES = 2,
  parameter int FREEZE_FRAMES  = 90,
  parameter int MATCH_FRAMES   = 5400,
  parameter int TIMER_W        = 13
) (
  input logic           frame_clk,
  input logic           Reset_n,
  goal_referee_if.slave bus
);

  localparam int CNT_W = (CONFIRM_FRAMES < 2) ? 1 : $clog2(CONFIRM_FRAMES + 1);
  localparam int FRZ_W = (FREEZE_FRAMES < 2) ? 1 : $clog2(FREEZE_FRAMES);
  localparam bit TIMED = (MATCH_FRAMES != 0);

  localparam logic [COORD_W:0]   LEFT_X    = (COORD_W+1)'(LEFT_GOAL_X);
  localparam logic [COORD_W:0]   RIGHT_X   = (COORD_W+1)'(RIGHT_GOAL_X);
  localparam logic [COORD_W-1:0] Y_TOP     = COORD_W'(GOAL_Y_TOP);
  localparam logic [COORD_W-1:0] Y_BOT     = COORD_W'(GOAL_Y_BOTTOM);
  localparam logic [CNT_W-1:0]   CONFIRM_N = CNT_W'(CONFIRM_FRAMES);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [FRZ_W-1:0]   FRZ_LOAD  = FRZ_W'(FREEZE_FRAMES - 1);
  localparam logic [FRZ_W-1:0]   FRZ_ONE   = FRZ_W'(1);
  localparam logic [SCORE_W-1:0] S_MAX     = SCORE_W'(SCORE_MAX);
  localparam logic [SCORE_W-1:0] S_ONE     = SCORE_W'(1);
  localparam logic [TIMER_W-1:0] T_INIT    = TIMER_W'(MATCH_FRAMES);
  localparam logic [TIMER_W-1:0] T_ONE     = TIMER_W'(1);

  typedef enum logic [1:0] {ST_PLAY, ST_FREEZE, ST_OVER} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               side_q, side_d;
  logic [FRZ_W-1:0]   frz_q, frz_d;
  logic [SCORE_W-1:0] p1_q, p1_d;
  logic [SCORE_W-1:0] p2_q, p2_d;
  logic               left_goal_q, left_goal_d;
  logic [TIMER_W-1:0] time_q, time_d;
  logic               ot_q, ot_d;
  logic               p1_wins_q, p1_wins_d;
  logic               goal_q, goal_d;
  logic               ball_reset_q, ball_reset_d;

  logic               in_y, in_left, in_right, in_goal;
  logic [CNT_W-1:0]   run_cnt;
  logic               confirm;
  logic [SCORE_W-1:0] p1_inc, p2_inc;
  logic               scorer_wins;
  logic               freeze_w, game_over_w;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s >= S_MAX) ? S_MAX : s + S_ONE;
  endfunction

  function automatic logic reaches_win(input logic [SCORE_W-1:0] mine,
                                       input logic [SCORE_W-1:0] theirs);
    return (int'(mine) >= WIN_SCORE) && (int'(mine) >= int'(theirs) + WIN_MARGIN);
  endfunction

  // Goal region; sums are one bit wider so a radius larger than x cannot wrap.
  always_comb begin
    in_y     = (bus.ball_y >= Y_TOP) && (bus.ball_y <= Y_BOT);
    in_left  = in_y && ({1'b0, bus.ball_x} <= LEFT_X + {1'b0, bus.ball_r});
    in_right = in_y && (({1'b0, bus.ball_x} + {1'b0, bus.ball_r}) >= RIGHT_X);
    in_goal  = in_left || in_right;
  end

  always_comb begin
    run_cnt = '0;
    if (in_goal) begin
      run_cnt = ((cnt_q != '0) && (side_q == in_left)) ? cnt_q + CNT_ONE : CNT_ONE;
    end
    confirm     = in_goal && (run_cnt == CONFIRM_N);
    p1_inc      = sat_inc(p1_q);
    p2_inc      = sat_inc(p2_q);
    scorer_wins = in_left ? reaches_win(p2_inc, p1_q) : reaches_win(p1_inc, p2_q);
  end

  // FSM: state register
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_PLAY;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state and datapath next values
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    side_d       = side_q;
    frz_d        = frz_q;
    p1_d         = p1_q;
    p2_d         = p2_q;
    left_goal_d  = left_goal_q;
    time_d       = time_q;
    ot_d         = ot_q;
    p1_wins_d    = p1_wins_q;
    goal_d       = 1'b0;
    ball_reset_d = 1'b0;

    if (bus.game_restart) begin
      state_d     = ST_PLAY;
      cnt_d       = '0;
      side_d      = 1'b0;
      frz_d       = '0;
      p1_d        = '0;
      p2_d        = '0;
      left_goal_d = 1'b0;
      time_d      = T_INIT;
      ot_d        = 1'b0;
      p1_wins_d   = 1'b0;
    end else if (!bus.pause) begin
      unique case (state_q)
        ST_PLAY: begin
          if (TIMED && (time_q != '0)) time_d = time_q - T_ONE;
          cnt_d = run_cnt;
          if (in_goal) side_d = in_left;
          if (confirm) begin
            // A goal in the expiry frame wins over expiry; expiry is re-checked after the freeze.
            goal_d      = 1'b1;
            left_goal_d = in_left;
            cnt_d       = '0;
            if (in_left) p2_d = p2_inc;
            else         p1_d = p1_inc;
            if (ot_q || scorer_wins) begin
              state_d   = ST_OVER;
              p1_wins_d = !in_left;
            end else begin
              state_d = ST_FREEZE;
              frz_d   = FRZ_LOAD;
            end
          end else if (TIMED && (time_q == '0) && !ot_q) begin
            if (p1_q != p2_q) begin
              state_d   = ST_OVER;
              p1_wins_d = (p1_q > p2_q);
            end else begin
              ot_d = 1'b1;
            end
          end
        end
        ST_FREEZE: begin
          cnt_d = '0;
          if (frz_q == '0) begin
            state_d      = ST_PLAY;
            ball_reset_d = 1'b1;
          end else begin
            frz_d = frz_q - FRZ_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  // FSM: state-decoded outputs
  always_comb begin
    freeze_w    = (state_q == ST_FREEZE);
    game_over_w = (state_q == ST_OVER);
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_q        <= '0;
      side_q       <= 1'b0;
      frz_q        <= '0;
      p1_q         <= '0;
      p2_q         <= '0;
      left_goal_q  <= 1'b0;
      time_q       <= T_INIT;
      ot_q         <= 1'b0;
      p1_wins_q    <= 1'b0;
      goal_q       <= 1'b0;
      ball_reset_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      side_q       <= side_d;
      frz_q        <= frz_d;
      p1_q         <= p1_d;
      p2_q         <= p2_d;
      left_goal_q  <= left_goal_d;
      time_q       <= time_d;
      ot_q         <= ot_d;
      p1_wins_q    <= p1_wins_d;
      goal_q       <= goal_d;
      ball_reset_q <= ball_reset_d;
    end
  end

  assign bus.goal_scored = goal_q;
  assign bus.left_goal   = left_goal_q;
  assign bus.p1_score    = p1_q;
  assign bus.p2_score    = p2_q;
  assign bus.freeze      = freeze_w;
  assign bus.ball_reset  = ball_reset_q;
  assign bus.time_left   = time_q;
  assign bus.overtime    = ot_q;
  assign bus.game_over   = game_over_w;
  assign bus.p1_wins     = p1_wins_q;

endmodule

// File: tb/tb_goal_referee.sv
// Bench for goal_referee: three differently parametrised instances share one ball stream
// and are compared every frame against a rule-level reference model, plus directed checks.
module tb_goal_referee;

  localparam int M_PLAY = 0;
  localparam int M_FRZ  = 1;
  localparam int M_OVER = 2;

  typedef struct {
    int mode; int streak; int streak_side; int frz_done;
    int s1; int s2; int lg; int tl; int ot; int p1w; int gs; int br;
  } mdl_t;

  typedef struct { int win_score; int win_margin; int confirm; int freeze; int match; } prm_t;

  logic       frame_clk = 1'b0;
  logic       Reset_n   = 1'b0;
  logic [9:0] bx = 10'd320, by = 10'd240, br = 10'd8;
  logic       restart = 1'b0, pz = 1'b0;

  int   n_checks = 0;
  int   n_err    = 0;
  mdl_t mdl [3];
  prm_t prm [3];

  always #5 frame_clk = ~frame_clk;

  goal_referee_if ifa ();
  goal_referee_if ifb ();
  goal_referee_if ifc ();

  assign ifa.ball_x = bx; assign ifa.ball_y = by; assign ifa.ball_r = br;
  assign ifa.game_restart = restart; assign ifa.pause = pz;
  assign ifb.ball_x = bx; assign ifb.ball_y = by; assign ifb.ball_r = br;
  assign ifb.game_restart = restart; assign ifb.pause = pz;
  assign ifc.ball_x = bx; assign ifc.ball_y = by; assign ifc.ball_r = br;
  assign ifc.game_restart = restart; assign ifc.pause = pz;

  goal_referee dut_a (.frame_clk(frame_clk), .Reset_n(Reset_n), .bus(ifa));

  goal_referee #(.WIN_MARGIN(2), .CONFIRM_FRAMES(3), .FREEZE_FRAMES(4), .MATCH_FRAMES(30))
    dut_b (.frame_clk(frame_clk), .Reset_n(Reset_n), .bus(ifb));

  goal_referee #(.WIN_SCORE(15), .CONFIRM_FRAMES(1), .FREEZE_FRAMES(1), .MATCH_FRAMES(0))
    dut_c (.frame_clk(frame_clk), .Reset_n(Reset_n), .bus(ifc));

  function automatic mdl_t mdl_reset(prm_t p);
    mdl_t n;
    n.mode = M_PLAY; n.streak = 0; n.streak_side = 0; n.frz_done = 0;
    n.s1 = 0; n.s2 = 0; n.lg = 0; n.tl = p.match; n.ot = 0; n.p1w = 0; n.gs = 0; n.br = 0;
    return n;
  endfunction

  // One frame of the match rules, written directly from the referee's behaviour.
  function automatic mdl_t mdl_step(mdl_t m, prm_t p, int x, int y, int r, bit rs, bit pause);
    mdl_t n = m;
    int side, scorer, opp;
    bit in_y;
    if (rs) return mdl_reset(p);
    n.gs = 0; n.br = 0;
    if (pause) return n;
    if (m.mode == M_PLAY) begin
      in_y = (y >= 176) && (y <= 316);
      side = 0;
      if (in_y && (x <= 32 + r)) side = 1;
      else if (in_y && (x + r >= 604)) side = 2;
      if (side == 0) n.streak = 0;
      else if (side == m.streak_side && m.streak > 0) n.streak = m.streak + 1;
      else n.streak = 1;
      n.streak_side = side;
      if (p.match != 0 && m.tl > 0) n.tl = m.tl - 1;
      if (side != 0 && n.streak == p.confirm) begin
        n.gs = 1; n.streak = 0; n.lg = (side == 1);
        if (side == 1) n.s2 = (m.s2 < 9) ? m.s2 + 1 : 9;
        else           n.s1 = (m.s1 < 9) ? m.s1 + 1 : 9;
        scorer = (side == 1) ? n.s2 : n.s1;
        opp    = (side == 1) ? n.s1 : n.s2;
        if (m.ot != 0 || (scorer >= p.win_score && scorer >= opp + p.win_margin)) begin
          n.mode = M_OVER; n.p1w = (side == 2);
        end else begin
          n.mode = M_FRZ; n.frz_done = 0;
        end
      end else if (p.match != 0 && m.tl == 0 && m.ot == 0) begin
        if (m.s1 != m.s2) begin n.mode = M_OVER; n.p1w = (m.s1 > m.s2); end
        else n.ot = 1;
      end
    end else if (m.mode == M_FRZ) begin
      n.streak   = 0;
      n.frz_done = m.frz_done + 1;
      if (n.frz_done == p.freeze) begin n.mode = M_PLAY; n.br = 1; end
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_inst(input string nm, input int k,
                          input logic [31:0] gs, input logic [31:0] lg,
                          input logic [31:0] s1, input logic [31:0] s2,
                          input logic [31:0] fr, input logic [31:0] brs,
                          input logic [31:0] tl, input logic [31:0] ot,
                          input logic [31:0] go, input logic [31:0] pw);
    chk({nm, ".goal_scored"}, gs,  mdl[k].gs);
    chk({nm, ".left_goal"},   lg,  mdl[k].lg);
    chk({nm, ".p1_score"},    s1,  mdl[k].s1);
    chk({nm, ".p2_score"},    s2,  mdl[k].s2);
    chk({nm, ".freeze"},      fr,  (mdl[k].mode == M_FRZ) ? 1 : 0);
    chk({nm, ".ball_reset"},  brs, mdl[k].br);
    chk({nm, ".time_left"},   tl,  mdl[k].tl);
    chk({nm, ".overtime"},    ot,  mdl[k].ot);
    chk({nm, ".game_over"},   go,  (mdl[k].mode == M_OVER) ? 1 : 0);
    chk({nm, ".p1_wins"},     pw,  mdl[k].p1w);
  endtask

  task automatic check_all();
    chk_inst("A", 0, ifa.goal_scored, ifa.left_goal, ifa.p1_score, ifa.p2_score, ifa.freeze,
             ifa.ball_reset, ifa.time_left, ifa.overtime, ifa.game_over, ifa.p1_wins);
    chk_inst("B", 1, ifb.goal_scored, ifb.left_goal, ifb.p1_score, ifb.p2_score, ifb.freeze,
             ifb.ball_reset, ifb.time_left, ifb.overtime, ifb.game_over, ifb.p1_wins);
    chk_inst("C", 2, ifc.goal_scored, ifc.left_goal, ifc.p1_score, ifc.p2_score, ifc.freeze,
             ifc.ball_reset, ifc.time_left, ifc.overtime, ifc.game_over, ifc.p1_wins);
  endtask

  task automatic reset_models();
    for (int k = 0; k < 3; k++) mdl[k] = mdl_reset(prm[k]);
  endtask

  task automatic tick();
    @(posedge frame_clk);
    for (int k = 0; k < 3; k++)
      mdl[k] = mdl_step(mdl[k], prm[k], int'(bx), int'(by), int'(br), restart, pz);
    #1;
    check_all();
  endtask

  task automatic set_ball(input int x, input int y, input int r);
    bx = 10'(x); by = 10'(y); br = 10'(r);
  endtask

  task automatic ball_out();
    set_ball(320, 240, 8);
  endtask

  initial begin
    int frz_cnt, hold, cat;
    prm[0] = '{win_score: 5,  win_margin: 1, confirm: 2, freeze: 90, match: 5400};
    prm[1] = '{win_score: 5,  win_margin: 2, confirm: 3, freeze: 4,  match: 30};
    prm[2] = '{win_score: 15, win_margin: 1, confirm: 1, freeze: 1,  match: 0};
    reset_models();

    // Reset values while Reset_n is held low
    #12;
    check_all();
    chk("A.time_left_reset", ifa.time_left, 5400);
    chk("B.time_left_reset", ifb.time_left, 30);
    chk("C.time_left_reset", ifc.time_left, 0);
    @(negedge frame_clk);
    Reset_n = 1'b1;

    // One in-goal frame is not enough, two consecutive frames score for P2
    set_ball(20, 200, 8);
    tick();
    ball_out();
    tick();
    chk("A.no_goal_single_frame", ifa.goal_scored, 0);
    set_ball(20, 200, 8);
    tick();
    tick();
    chk("A.goal_pulse", ifa.goal_scored, 1);
    chk("A.p2_first_goal", ifa.p2_score, 1);
    chk("A.left_goal_side", ifa.left_goal, 1);
    ball_out();
    frz_cnt = ifa.freeze ? 1 : 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (!ifa.freeze) break;
      frz_cnt++;
    end
    chk("A.freeze_length", frz_cnt, 90);
    chk("A.ball_reset_after_freeze", ifa.ball_reset, 1);

    // Radius larger than x still counts as a left goal; right goal credits P1
    set_ball(3, 200, 8);
    tick();
    tick();
    chk("A.p2_x_lt_r", ifa.p2_score, 2);
    ball_out();
    repeat (92) tick();
    set_ball(600, 200, 8);
    tick();
    tick();
    chk("A.p1_right_goal", ifa.p1_score, 1);
    chk("A.left_goal_right", ifa.left_goal, 0);
    ball_out();
    repeat (92) tick();

    // Four more right goals end the match for P1; OVER ignores further goals
    for (int g = 0; g < 4; g++) begin
      set_ball(600, 250, 8);
      tick();
      tick();
      ball_out();
      if (g < 3) repeat (92) tick();
    end
    chk("A.game_over_win", ifa.game_over, 1);
    chk("A.p1_wins", ifa.p1_wins, 1);
    set_ball(600, 250, 8);
    repeat (5) tick();
    chk("A.over_no_goal", ifa.goal_scored, 0);
    chk("A.over_score_held", ifa.p1_score, 5);

    // Restart from OVER
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("A.restart_game_over", ifa.game_over, 0);
    chk("A.restart_p1", ifa.p1_score, 0);
    chk("A.restart_time", ifa.time_left, 5400);

    // Randomised play: held ball positions, random pause, rare restarts
    hold = 0;
    for (int i = 0; i < 4000; i++) begin
      if (hold == 0) begin
        hold = $urandom_range(1, 4);
        cat  = $urandom_range(0, 9);
        if (cat < 3)       set_ball($urandom_range(0, 60), $urandom_range(150, 340), $urandom_range(0, 20));
        else if (cat < 6)  set_ball($urandom_range(570, 640), $urandom_range(150, 340), $urandom_range(0, 20));
        else if (cat == 6) set_ball($urandom_range(200, 1023), $urandom_range(176, 316), $urandom_range(400, 1023));
        else               set_ball($urandom_range(100, 500), $urandom_range(0, 1023), $urandom_range(0, 20));
      end
      hold--;
      pz      = ($urandom_range(0, 9) == 0);
      restart = ($urandom_range(0, 399) == 0);
      tick();
    end
    pz = 1'b0;
    restart = 1'b0;

    // Asynchronous reset in the middle of a confirm window
    set_ball(600, 200, 8);
    tick();
    #2;
    Reset_n = 1'b0;
    #1;
    reset_models();
    check_all();
    chk("A.async_time", ifa.time_left, 5400);
    chk("A.async_freeze", ifa.freeze, 0);
    @(negedge frame_clk);
    Reset_n = 1'b1;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
